// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle CPU main controller: ALU commands,
// opcode/funct codes, datapath mux selects and the controller state set.
package mc_control_fsm_pkg;

  localparam int STATE_BITS = 4;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic SRC_A_PC   = 1'b0;
  localparam logic SRC_A_REGA = 1'b1;

  localparam logic [2:0] SRC_B_REGB    = 3'd0;
  localparam logic [2:0] SRC_B_CONST4  = 3'd1;
  localparam logic [2:0] SRC_B_SEXT    = 3'd2;
  localparam logic [2:0] SRC_B_SEXT_SH = 3'd3;
  localparam logic [2:0] SRC_B_ZEXT    = 3'd4;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REGA   = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EX_R     = 4'd6,
    S_WB_R     = 4'd7,
    S_EX_I     = 4'd8,
    S_WB_I     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  // First state after DECODE; FETCH here means the instruction is unsupported.
  function automatic state_t decode_next(input logic [5:0] opcode, input logic [5:0] funct);
    state_t result;
    result = S_FETCH;
    case (opcode)
      OP_LW, OP_SW:     result = S_MEM_ADDR;
      OP_ADDI, OP_XORI: result = S_EX_I;
      OP_BEQ, OP_BNE:   result = S_BRANCH;
      OP_J:             result = S_JUMP;
      OP_JAL:           result = S_JAL;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: result = S_EX_R;
          FN_JR:                  result = S_JR;
          default:                result = S_FETCH;
        endcase
      end
      default: result = S_FETCH;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_op_decode.sv
// Combinational ALU command selection from the controller state and the
// current instruction's opcode/funct fields.
module mc_control_fsm_alu_op_decode
  import mc_control_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_command
);

  always_comb begin
    alu_command = ALU_ADD;
    case (state)
      S_EX_R: begin
        case (funct)
          FN_SUB:  alu_command = ALU_SUB;
          FN_SLT:  alu_command = ALU_SLT;
          default: alu_command = ALU_ADD;
        endcase
      end
      S_EX_I:   alu_command = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
      S_BRANCH: alu_command = ALU_SUB;
      default:  alu_command = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU main controller: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives ALU and datapath controls.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  output logic [2:0]         alu_command,
  output logic               alu_src_a,
  output logic [2:0]         alu_src_b,
  output logic               iord,
  output logic               ir_we,
  output logic               pc_we,
  output logic               mem_we,
  output logic               reg_we,
  output logic [1:0]         pc_src,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic       is_store_q;
  logic [2:0] decoded_cmd;

  // LW/SW is captured in DECODE so MEM_ADDR can branch without re-reading the IR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        is_store_q <= (opcode == OP_SW);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = decode_next(opcode, funct);
      S_MEM_ADDR: state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_WB_MEM;
      S_EX_R:     state_d = S_WB_R;
      S_EX_I:     state_d = S_WB_I;
      S_WB_MEM, S_MEM_WR, S_WB_R, S_WB_I,
      S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_control_fsm_alu_op_decode u_alu_op_decode (
    .state       (state_q),
    .opcode      (opcode),
    .funct       (funct),
    .alu_command (decoded_cmd)
  );

  // Reset gates every output so an abandoned instruction cannot write anything.
  always_comb begin
    alu_command = ALU_ADD;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_REGB;
    iord        = IORD_PC;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    pc_src      = PC_SRC_ALU;
    reg_dst     = REG_DST_RT;
    mem_to_reg  = M2R_ALUOUT;
    illegal     = 1'b0;
    if (!reset) begin
      alu_command = decoded_cmd;
      case (state_q)
        S_FETCH: begin
          iord      = IORD_PC;
          ir_we     = 1'b1;
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_CONST4;
          pc_src    = PC_SRC_ALU;
          pc_we     = 1'b1;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_SEXT_SH;
          illegal   = (decode_next(opcode, funct) == S_FETCH);
        end
        S_MEM_ADDR: begin
          alu_src_a = SRC_A_REGA;
          alu_src_b = SRC_B_SEXT;
        end
        S_MEM_RD: iord = IORD_ALUOUT;
        S_WB_MEM: begin
          reg_we     = 1'b1;
          reg_dst    = REG_DST_RT;
          mem_to_reg = M2R_MDR;
        end
        S_MEM_WR: begin
          iord   = IORD_ALUOUT;
          mem_we = 1'b1;
        end
        S_EX_R: begin
          alu_src_a = SRC_A_REGA;
          alu_src_b = SRC_B_REGB;
        end
        S_WB_R: begin
          reg_we     = 1'b1;
          reg_dst    = REG_DST_RD;
          mem_to_reg = M2R_ALUOUT;
        end
        S_EX_I: begin
          alu_src_a = SRC_A_REGA;
          alu_src_b = (opcode == OP_XORI) ? SRC_B_ZEXT : SRC_B_SEXT;
        end
        S_WB_I: begin
          reg_we     = 1'b1;
          reg_dst    = REG_DST_RT;
          mem_to_reg = M2R_ALUOUT;
        end
        S_BRANCH: begin
          alu_src_a = SRC_A_REGA;
          alu_src_b = SRC_B_REGB;
          pc_src    = PC_SRC_ALUOUT;
          pc_we     = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
        end
        S_JUMP: begin
          pc_src = PC_SRC_JUMP;
          pc_we  = 1'b1;
        end
        // PC already holds PC+4 here, so the link value is taken straight from PC.
        S_JAL: begin
          pc_src     = PC_SRC_JUMP;
          pc_we      = 1'b1;
          reg_we     = 1'b1;
          reg_dst    = REG_DST_RA;
          mem_to_reg = M2R_PC;
        end
        S_JR: begin
          pc_src = PC_SRC_REGA;
          pc_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule
